// File: rtl/ysyx_22041412_issue_ctrl.sv
// In-order issue controller: holds decoded instructions at the ID/EX boundary until
// RAW/WAW, mul/div + LSU structural, and branch control hazards clear.

`ifndef ysyx_22041412_MEM_IDLE
`define ysyx_22041412_MEM_IDLE 2'b00
`endif
`ifndef ysyx_22041412_MEM_LOAD
`define ysyx_22041412_MEM_LOAD 2'b01
`endif
`ifndef ysyx_22041412_MEM_STOR
`define ysyx_22041412_MEM_STOR 2'b10
`endif
`ifndef ysyx_22041412_J_IDLE
`define ysyx_22041412_J_IDLE 2'b00
`endif
`ifndef ysyx_22041412_J_JAL
`define ysyx_22041412_J_JAL 2'b01
`endif
`ifndef ysyx_22041412_J_JALR
`define ysyx_22041412_J_JALR 2'b10
`endif
`ifndef ysyx_22041412_j_B
`define ysyx_22041412_j_B 2'b11
`endif

module ysyx_22041412_issue_ctrl #(
  parameter int unsigned SB_REGS = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_mul_en,
  input  logic             id_div_en,
  input  logic [1:0]       id_mem_mode,
  input  logic [1:0]       id_jump_mode,
  output logic             id_ready,
  output logic             issue_valid,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             mdu_done,
  input  logic             lsu_done,
  input  logic             br_resolve,
  input  logic             br_taken,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {StRun, StBrWait} state_e;

  state_e             state_q, state_d;
  logic [SB_REGS-1:0] sb_q, sb_d;
  logic               mdu_busy_q, mdu_busy_d;
  logic               lsu_busy_q, lsu_busy_d;
  logic               flush_q, flush_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic raw, waw, strct, ctrl, fire;
  logic mdu_op, mem_op, br_op;

  assign mdu_op = id_mul_en | id_div_en;
  assign mem_op = (id_mem_mode != `ysyx_22041412_MEM_IDLE);
  // jal has its target resolved in decode, so only jalr and B wait for execute.
  assign br_op  = (id_jump_mode == `ysyx_22041412_J_JALR) | (id_jump_mode == `ysyx_22041412_j_B);

  // Hazards look at registered state only; a same-cycle writeback does not bypass.
  assign raw   = ((id_rs1 != 5'd0) & sb_q[id_rs1]) | ((id_rs2 != 5'd0) & sb_q[id_rs2]);
  assign waw   = (id_rd != 5'd0) & sb_q[id_rd];
  assign strct = (mdu_op & mdu_busy_q) | (mem_op & lsu_busy_q);
  assign ctrl  = (state_q == StBrWait);

  assign id_ready    = rst_n & ex_ready & ~raw & ~waw & ~strct & ~ctrl & ~flush_q;
  assign issue_valid = id_valid & id_ready;
  assign fire        = issue_valid;

  assign flush_id  = flush_q;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    sb_d        = sb_q;
    mdu_busy_d  = mdu_busy_q;
    lsu_busy_d  = lsu_busy_q;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;

    // Clear first so a same-index set in the same cycle wins.
    if (wb_valid && (wb_rd != 5'd0)) sb_d[wb_rd] = 1'b0;
    if (fire && (id_rd != 5'd0))     sb_d[id_rd] = 1'b1;
    sb_d[0] = 1'b0;

    if (fire && mdu_op)  mdu_busy_d = 1'b1;
    else if (mdu_done)   mdu_busy_d = 1'b0;

    if (fire && mem_op)  lsu_busy_d = 1'b1;
    else if (lsu_done)   lsu_busy_d = 1'b0;

    unique case (state_q)
      StRun:    if (fire && br_op) state_d = StBrWait;
      StBrWait: if (br_resolve)    state_d = StRun;
      default:                     state_d = StRun;
    endcase

    flush_d = br_resolve & br_taken & (state_q == StBrWait);

    if (id_valid && !id_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_q        <= '0;
      mdu_busy_q  <= 1'b0;
      lsu_busy_q  <= 1'b0;
      state_q     <= StRun;
      flush_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      mdu_busy_q  <= mdu_busy_d;
      lsu_busy_q  <= lsu_busy_d;
      state_q     <= state_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_issue_ctrl.sv
// Bench for ysyx_22041412_issue_ctrl: directed hazard scenarios plus a randomized run
// against a pending-set / busy-flag reference model.

`ifndef ysyx_22041412_MEM_IDLE
`define ysyx_22041412_MEM_IDLE 2'b00
`endif
`ifndef ysyx_22041412_MEM_LOAD
`define ysyx_22041412_MEM_LOAD 2'b01
`endif
`ifndef ysyx_22041412_MEM_STOR
`define ysyx_22041412_MEM_STOR 2'b10
`endif
`ifndef ysyx_22041412_J_IDLE
`define ysyx_22041412_J_IDLE 2'b00
`endif
`ifndef ysyx_22041412_J_JAL
`define ysyx_22041412_J_JAL 2'b01
`endif
`ifndef ysyx_22041412_J_JALR
`define ysyx_22041412_J_JALR 2'b10
`endif
`ifndef ysyx_22041412_j_B
`define ysyx_22041412_j_B 2'b11
`endif

module tb_ysyx_22041412_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_mul_en, id_div_en;
  logic [1:0]  id_mem_mode, id_jump_mode;
  logic        id_ready, issue_valid, id_ready_s, issue_valid_s;
  logic        ex_ready, wb_valid;
  logic [4:0]  wb_rd;
  logic        mdu_done, lsu_done, br_resolve, br_taken;
  logic        flush_id, flush_id_s;
  logic [31:0] stall_cnt;
  logic [2:0]  stall_cnt_s;

  int checks = 0;
  int errors = 0;

  // Reference model: set of pending registers, resource flags, branch-wait flag.
  bit [31:0] pend;
  bit        m_mdu, m_lsu, m_brw, m_flush;
  bit [31:0] m_stall;
  int        m_stall_s;

  always #5 clk = ~clk;

  ysyx_22041412_issue_ctrl #(.SB_REGS(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_mul_en(id_mul_en), .id_div_en(id_div_en), .id_mem_mode(id_mem_mode),
    .id_jump_mode(id_jump_mode), .id_ready(id_ready), .issue_valid(issue_valid),
    .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .mdu_done(mdu_done),
    .lsu_done(lsu_done), .br_resolve(br_resolve), .br_taken(br_taken), .flush_id(flush_id),
    .stall_cnt(stall_cnt)
  );

  // Narrow counter instance so saturation is reachable.
  ysyx_22041412_issue_ctrl #(.SB_REGS(32), .CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_mul_en(id_mul_en), .id_div_en(id_div_en), .id_mem_mode(id_mem_mode),
    .id_jump_mode(id_jump_mode), .id_ready(id_ready_s), .issue_valid(issue_valid_s),
    .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .mdu_done(mdu_done),
    .lsu_done(lsu_done), .br_resolve(br_resolve), .br_taken(br_taken), .flush_id(flush_id_s),
    .stall_cnt(stall_cnt_s)
  );

  function automatic bit exp_ready();
    bit busy_res;
    bit dep;
    if (!rst_n || !ex_ready || m_brw || m_flush) return 1'b0;
    dep = (id_rs1 != 0 && pend[id_rs1]) || (id_rs2 != 0 && pend[id_rs2]) ||
          (id_rd != 0 && pend[id_rd]);
    busy_res = ((id_mul_en || id_div_en) && m_mdu) ||
               (id_mem_mode != `ysyx_22041412_MEM_IDLE && m_lsu);
    return !dep && !busy_res;
  endfunction

  task automatic model_edge();
    bit r, f, is_br;
    r = exp_ready();
    f = id_valid && r;
    if (!rst_n) begin
      pend = '0; m_mdu = 0; m_lsu = 0; m_brw = 0; m_flush = 0; m_stall = 0; m_stall_s = 0;
      return;
    end
    if (id_valid && !r) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall++;
      if (m_stall_s < 7) m_stall_s++;
    end
    if (wb_valid && wb_rd != 0) pend[wb_rd] = 1'b0;
    if (f && id_rd != 0) pend[id_rd] = 1'b1;
    if (f && (id_mul_en || id_div_en)) m_mdu = 1;
    else if (mdu_done) m_mdu = 0;
    if (f && id_mem_mode != `ysyx_22041412_MEM_IDLE) m_lsu = 1;
    else if (lsu_done) m_lsu = 0;
    m_flush = br_resolve && br_taken && m_brw;
    is_br = (id_jump_mode == `ysyx_22041412_J_JALR) || (id_jump_mode == `ysyx_22041412_j_B);
    if (m_brw) m_brw = !br_resolve;
    else if (f && is_br) m_brw = 1;
  endtask

  // Advance one clock; leaves time at the following negedge for driving inputs.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_instr(input bit v, input int rs1, input int rs2, input int rd,
                           input bit mul, input bit dv, input bit [1:0] mem,
                           input bit [1:0] jmp);
    id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_mul_en = mul; id_div_en = dv; id_mem_mode = mem; id_jump_mode = jmp;
  endtask

  task automatic quiet();
    wb_valid = 0; wb_rd = 0; mdu_done = 0; lsu_done = 0; br_resolve = 0; br_taken = 0;
    ex_ready = 1;
  endtask

  task automatic do_reset();
    quiet();
    set_instr(0, 0, 0, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    quiet();
    rst_n = 0;
    set_instr(1, 0, 0, 1, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    tick();
    #1;
    if (id_ready !== 1'b0 || issue_valid !== 1'b0) begin
      $display("FAIL reset_hold: id_ready=%b issue_valid=%b exp 0 0", id_ready, issue_valid);
      errors++;
    end
    checks++;
    tick();
    rst_n = 1;
    #1;
    if (flush_id !== 1'b0 || stall_cnt !== 32'd0 || stall_cnt_s !== 3'd0) begin
      $display("FAIL reset_state: flush=%b cnt=%0d cnt_s=%0d exp 0 0 0",
               flush_id, stall_cnt, stall_cnt_s);
      errors++;
    end
    checks++;
    if (id_ready !== 1'b1 || issue_valid !== 1'b1) begin
      $display("FAIL reset_first_issue: id_ready=%b issue_valid=%b exp 1 1", id_ready, issue_valid);
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_raw_load();
    do_reset();
    set_instr(1, 0, 0, 5, 0, 0, `ysyx_22041412_MEM_LOAD, `ysyx_22041412_J_IDLE);
    #1;
    if (issue_valid !== 1'b1) begin
      $display("FAIL raw_load_fire: issue_valid=%b exp 1", issue_valid); errors++;
    end
    checks++;
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_instr(1, 5, 0, 6, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
      lsu_done = (i == 2);
      wb_valid = (i == 4); wb_rd = 5;
      #1;
      if (id_ready !== 1'b0) begin
        $display("FAIL raw_stall c%0d: id_ready=%b exp 0", i, id_ready); errors++;
      end
      checks++;
      tick();
    end
    quiet();
    #1;
    if (issue_valid !== 1'b1 || stall_cnt !== 32'd4 || stall_cnt_s !== 3'd4) begin
      $display("FAIL raw_release: issue_valid=%b cnt=%0d cnt_s=%0d exp 1 4 4",
               issue_valid, stall_cnt, stall_cnt_s);
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_mul_div();
    do_reset();
    set_instr(1, 0, 0, 3, 1, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    #1;
    if (issue_valid !== 1'b1) begin
      $display("FAIL mul_fire: issue_valid=%b exp 1", issue_valid); errors++;
    end
    checks++;
    tick();
    for (int i = 1; i <= 10; i++) begin
      set_instr(1, 1, 2, 7, 0, 1, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
      mdu_done = (i == 10);
      #1;
      if (id_ready !== 1'b0) begin
        $display("FAIL div_struct c%0d: id_ready=%b exp 0", i, id_ready); errors++;
      end
      checks++;
      tick();
    end
    mdu_done = 0;
    #1;
    if (issue_valid !== 1'b1) begin
      $display("FAIL div_release: issue_valid=%b exp 1", issue_valid); errors++;
    end
    checks++;
    tick();
    set_instr(1, 3, 0, 8, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    wb_valid = 1; wb_rd = 3;
    #1;
    if (id_ready !== 1'b0) begin
      $display("FAIL x3_still_pending: id_ready=%b exp 0", id_ready); errors++;
    end
    checks++;
    tick();
    wb_valid = 0;
    #1;
    if (issue_valid !== 1'b1) begin
      $display("FAIL x3_after_wb: issue_valid=%b exp 1", issue_valid); errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    set_instr(1, 1, 2, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_j_B);
    #1;
    if (issue_valid !== 1'b1) begin
      $display("FAIL br_fire: issue_valid=%b exp 1", issue_valid); errors++;
    end
    checks++;
    tick();
    for (int i = 1; i <= 3; i++) begin
      set_instr(1, 0, 0, 4, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
      br_resolve = (i == 3); br_taken = (i == 3);
      #1;
      if (id_ready !== 1'b0 || flush_id !== 1'b0) begin
        $display("FAIL br_wait c%0d: id_ready=%b flush=%b exp 0 0", i, id_ready, flush_id);
        errors++;
      end
      checks++;
      tick();
    end
    quiet();
    #1;
    if (flush_id !== 1'b1 || id_ready !== 1'b0) begin
      $display("FAIL br_flush: flush=%b id_ready=%b exp 1 0", flush_id, id_ready); errors++;
    end
    checks++;
    tick();
    #1;
    if (flush_id !== 1'b0 || issue_valid !== 1'b1) begin
      $display("FAIL br_resume: flush=%b issue_valid=%b exp 0 1", flush_id, issue_valid);
      errors++;
    end
    checks++;
    tick();
    // Not-taken jalr: no flush, issue resumes right after resolve.
    set_instr(1, 1, 0, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_JALR);
    tick();
    set_instr(1, 0, 0, 6, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    br_resolve = 1; br_taken = 0;
    tick();
    quiet();
    #1;
    if (flush_id !== 1'b0 || issue_valid !== 1'b1) begin
      $display("FAIL br_not_taken: flush=%b issue_valid=%b exp 0 1", flush_id, issue_valid);
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    set_instr(1, 0, 0, 9, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    wb_valid = 1; wb_rd = 9;
    #1;
    if (issue_valid !== 1'b1) begin
      $display("FAIL coll_fire: issue_valid=%b exp 1", issue_valid); errors++;
    end
    checks++;
    tick();
    wb_valid = 0;
    set_instr(1, 0, 9, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    #1;
    if (id_ready !== 1'b0) begin
      $display("FAIL coll_set_wins: id_ready=%b exp 0", id_ready); errors++;
    end
    checks++;
    wb_valid = 1; wb_rd = 9;
    tick();
    wb_valid = 0;
    #1;
    if (issue_valid !== 1'b1) begin
      $display("FAIL coll_release: issue_valid=%b exp 1", issue_valid); errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_special();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_instr(1, 0, 0, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_JAL);
        1: set_instr(1, 0, 0, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
        2: set_instr(1, 0, 0, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_JAL);
        default: set_instr(1, 1, 2, 3, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
      endcase
      #1;
      if (issue_valid !== 1'b1) begin
        $display("FAIL special c%0d: issue_valid=%b exp 1", i, issue_valid); errors++;
      end
      checks++;
      tick();
    end
    quiet();
    set_instr(0, 0, 0, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    #1;
    if (stall_cnt !== 32'd0) begin
      $display("FAIL special_nostall: cnt=%0d exp 0", stall_cnt); errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_instr(1, 0, 0, 4, 1, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    tick();
    set_instr(1, 1, 0, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_j_B);
    tick();
    set_instr(1, 4, 0, 4, 1, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    #1;
    if (id_ready !== 1'b0) begin
      $display("FAIL mid_blocked: id_ready=%b exp 0", id_ready); errors++;
    end
    checks++;
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    if (issue_valid !== 1'b1 || flush_id !== 1'b0 || stall_cnt !== 32'd0) begin
      $display("FAIL mid_cleared: issue_valid=%b flush=%b cnt=%0d exp 1 0 0",
               issue_valid, flush_id, stall_cnt);
      errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    ex_ready = 0;
    set_instr(1, 0, 0, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    for (int i = 0; i < 10; i++) tick();
    ex_ready = 1;
    id_valid = 0;
    #1;
    if (stall_cnt !== 32'd10 || stall_cnt_s !== 3'd7) begin
      $display("FAIL saturate: cnt=%0d cnt_s=%0d exp 10 7", stall_cnt, stall_cnt_s); errors++;
    end
    checks++;
    tick();
  endtask

  task automatic test_random();
    bit held = 0;
    bit e;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if (!held) begin
        set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 2)),
                  ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      ex_ready   = ($urandom_range(0, 7) != 0);
      wb_valid   = ($urandom_range(0, 2) == 0);
      wb_rd      = 5'($urandom_range(0, 7));
      mdu_done   = ($urandom_range(0, 4) == 0);
      lsu_done   = ($urandom_range(0, 3) == 0);
      br_resolve = ($urandom_range(0, 3) == 0);
      br_taken   = ($urandom_range(0, 1) == 0);
      #1;
      e = exp_ready();
      if (id_ready !== e || issue_valid !== (id_valid && e)) begin
        $display("FAIL rnd_issue cyc%0d: ready=%b valid=%b exp %b %b",
                 c, id_ready, issue_valid, e, id_valid && e);
        errors++;
      end
      checks++;
      if (flush_id !== m_flush || stall_cnt !== m_stall || stall_cnt_s !== 3'(m_stall_s)) begin
        $display("FAIL rnd_regs cyc%0d: flush=%b cnt=%0d cnt_s=%0d exp %b %0d %0d",
                 c, flush_id, stall_cnt, stall_cnt_s, m_flush, m_stall, m_stall_s);
        errors++;
      end
      checks++;
      held = id_valid && !e && rst_n;
      tick();
    end
  endtask

  initial begin
    quiet();
    rst_n = 0;
    set_instr(0, 0, 0, 0, 0, 0, `ysyx_22041412_MEM_IDLE, `ysyx_22041412_J_IDLE);
    test_reset();
    test_raw_load();
    test_mul_div();
    test_branch();
    test_collision();
    test_special();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
